// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
package apb_arb_pkg;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_arb_st_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after ptr (with wrap) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Walk offsets from farthest to nearest so the nearest pending requester is the last one written.
    always_comb begin
        logic [IDX_W-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (req[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters; runs one SETUP->ACCESS transfer per grant.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      pclk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    apb_arb_st_t          state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
    logic             timeout_hit;

    // Expiry only counts when pready is low, so a late pready still completes normally.
    assign timeout_hit = (state_q == ACCESS) && !pready && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Count consecutive stalled ACCESS cycles; cleared everywhere else.
    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS && !pready && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // State and all registered outputs; reset leaves the bus idle with req[0] first in line.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            winner_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            done_q      <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            done_q      <= done_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state: one SETUP cycle, ACCESS until pready (or expiry), one RESP cycle back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d = RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath: latch the winner at grant, hold through ACCESS, pulse done, then clear.
    always_comb begin
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        done_d      = '0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = |(req_write & grant);
                    paddr_d   = req_addr[grant_idx*ADDR_W +: ADDR_W];
                    pwdata_d  = req_wdata[grant_idx*DATA_W +: DATA_W];
                    ptr_d     = grant_idx;
                    winner_d  = grant_idx;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    psel_d           = 1'b0;
                    penable_d        = 1'b0;
                    done_d[winner_q] = 1'b1;
                    rsp_rdata_d      = pwrite_q ? '0 : prdata;
`ifdef APB_ARB_TIMEOUT_EN
                    rsp_err_d        = 1'b0;
`endif
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    psel_d           = 1'b0;
                    penable_d        = 1'b0;
                    done_d[winner_q] = 1'b1;
                    rsp_rdata_d      = '0;
                    rsp_err_d        = 1'b1;
                end
`endif
            end
            RESP: begin
                rsp_rdata_d = '0;
                paddr_d     = '0;
                pwdata_d    = '0;
                pwrite_d    = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
                rsp_err_d   = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign done      = done_q;
    assign rsp_rdata = rsp_rdata_q;
    assign paddr     = paddr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter with a registered-pready APB memory completer.
// Timeout checks are included when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 32;

    typedef struct {
        int          idx;
        bit          wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic            pclk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic            pready;
    logic [DW-1:0]   prdata;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit   stall;
    logic pready_r;
    logic [DW-1:0] mem [512];

    apb_master_arbiter dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Memory completer: mem[i]=i after reset, pready one cycle into ACCESS unless stalled.
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pready_r <= 1'b0;
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i);
        end else begin
            pready_r <= psel && penable && !pready_r && !stall;
            if (psel && penable && pready_r && pwrite) mem[paddr] <= pwdata;
        end
    end
    assign pready = pready_r;
    assign prdata = mem[paddr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got no response expected done within budget", name);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge pclk) begin
        if (rst_n && done !== '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got %b expected none", done);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("done_onehot", 32'(done), 32'(1) << mon_e.idx);
                checkOutput("rsp_rdata", rsp_rdata, mon_e.rdata);
                checkOutput("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                checkOutput("psel_at_done", 32'(psel), 32'd0);
            end
        end
    end

    task automatic loadRequester(input int idx, input bit wr, input logic [8:0] addr, input logic [31:0] wdata);
        req_write[idx]         = wr;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = wdata;
    endtask

    // Single transfer: check SETUP/ACCESS bus values, drop req on done, then check the idle bus.
    task automatic applyStimulus(input vec_t v, output int acc_cnt);
        bit seen_done = 0;
        bit chk_bus   = 0;
        int setup_cnt = 0;
        acc_cnt = 0;
        @(negedge pclk);
        loadRequester(v.idx, v.wr, v.addr, v.wdata);
        sb.push_back('{idx: v.idx, rdata: v.exp_rdata, err: v.exp_err});
        req[v.idx] = 1'b1;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(negedge pclk);
            if (psel && !penable) setup_cnt++;
            if (psel && penable) begin
                acc_cnt++;
                if (!chk_bus) begin
                    chk_bus = 1;
                    checkOutput("paddr", 32'(paddr), 32'(v.addr));
                    checkOutput("pwrite", 32'(pwrite), 32'(v.wr));
                    if (v.wr) checkOutput("pwdata", pwdata, v.wdata);
                    checkOutput("setup_cycles", 32'(setup_cnt), 32'd1);
                end
            end
            if (done[v.idx]) begin
                seen_done  = 1;
                req[v.idx] = 1'b0;
            end
        end
        if (!seen_done) begin
            failNow("done_timeout");
            req[v.idx] = 1'b0;
        end
        @(negedge pclk);
        checkOutput("idle_psel", 32'(psel), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_rdata", rsp_rdata, 32'd0);
        checkOutput("idle_paddr", 32'(paddr), 32'd0);
        checkOutput("idle_pwrite", 32'(pwrite), 32'd0);
    endtask

    // Several requesters at once: drop each on its own done, psel must idle between transfers.
    task automatic runPending(input logic [N-1:0] mask);
        int   low_cnt = 1;
        logic prev_psel;
        prev_psel = psel;
        req = mask;
        for (int c = 0; c < 300 && req != '0; c++) begin
            @(negedge pclk);
            if (psel && !prev_psel) checkOutput("psel_gap", 32'(low_cnt >= 1), 32'd1);
            if (psel) low_cnt = 0;
            else low_cnt++;
            prev_psel = psel;
            req = req & ~done;
        end
        if (req != '0) begin
            failNow("pending_timeout");
            req = '0;
        end
        @(negedge pclk);
    endtask

    vec_t vecs[7];

    initial begin
        int acc;
        bit got;
        bit seen_psel;

        vecs[0] = '{idx: 0, wr: 0, addr: 9'h005, wdata: 32'h0,        exp_rdata: 32'h5,        exp_err: 0};
        vecs[1] = '{idx: 1, wr: 1, addr: 9'h010, wdata: 32'hDEADBEEF, exp_rdata: 32'h0,        exp_err: 0};
        vecs[2] = '{idx: 1, wr: 0, addr: 9'h010, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF, exp_err: 0};
        vecs[3] = '{idx: 2, wr: 0, addr: 9'h1FF, wdata: 32'h0,        exp_rdata: 32'h1FF,      exp_err: 0};
        vecs[4] = '{idx: 3, wr: 1, addr: 9'h1FF, wdata: 32'h12345678, exp_rdata: 32'h0,        exp_err: 0};
        vecs[5] = '{idx: 0, wr: 0, addr: 9'h1FF, wdata: 32'h0,        exp_rdata: 32'h12345678, exp_err: 0};
        vecs[6] = '{idx: 3, wr: 0, addr: 9'h000, wdata: 32'h0,        exp_rdata: 32'h0,        exp_err: 0};

        rst_n     = 1'b0;
        stall     = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        $display("[TB] reset state");
        checkOutput("rst_psel", 32'(psel), 32'd0);
        checkOutput("rst_penable", 32'(penable), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_paddr", 32'(paddr), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], acc);

        $display("[TB] four-way rotation");
        for (int i = 0; i < N; i++) begin
            loadRequester(i, 1'b0, 9'(9'h20 + i), 32'h0);
            sb.push_back('{idx: i, rdata: 32'h20 + 32'(i), err: 1'b0});
        end
        runPending(4'b1111);

        $display("[TB] req2/req3 after req3 served");
        loadRequester(2, 1'b0, 9'h030, 32'h0);
        loadRequester(3, 1'b0, 9'h031, 32'h0);
        sb.push_back('{idx: 2, rdata: 32'h30, err: 1'b0});
        sb.push_back('{idx: 3, rdata: 32'h31, err: 1'b0});
        runPending(4'b1100);

        $display("[TB] inputs changed and req dropped mid-transfer");
        loadRequester(1, 1'b0, 9'h005, 32'h0);
        sb.push_back('{idx: 1, rdata: 32'h5, err: 1'b0});
        req[1] = 1'b1;
        for (int c = 0; c < 20 && !psel; c++) @(negedge pclk);
        if (!psel) failNow("grant_timeout");
        loadRequester(1, 1'b1, 9'h006, 32'hFFFFFFFF);
        req[1] = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge pclk);
            if (psel && penable) checkOutput("latched_paddr", 32'(paddr), 32'h5);
            if (done != '0) got = 1;
        end
        if (!got) failNow("dropped_req_done");
        seen_psel = 0;
        repeat (6) begin
            @(negedge pclk);
            if (psel) seen_psel = 1;
        end
        checkOutput("no_regrant", 32'(seen_psel), 32'd0);

`ifdef APB_ARB_TIMEOUT_EN
        $display("[TB] access timeout");
        stall = 1'b1;
        applyStimulus('{idx: 1, wr: 0, addr: 9'h008, wdata: 32'h0, exp_rdata: 32'h0, exp_err: 1}, acc);
        checkOutput("timeout_access_cycles", 32'(acc), 32'd16);
        stall = 1'b0;
`endif

        $display("[TB] reset during ACCESS");
        stall = 1'b1;
        loadRequester(2, 1'b0, 9'h007, 32'h0);
        req[2] = 1'b1;
        for (int c = 0; c < 20 && !(psel && penable); c++) @(negedge pclk);
        if (!(psel && penable)) failNow("access_timeout");
        @(negedge pclk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_psel", 32'(psel), 32'd0);
        checkOutput("async_penable", 32'(penable), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        req   = '0;
        stall = 1'b0;
        @(negedge pclk);
        rst_n = 1'b1;
        loadRequester(0, 1'b0, 9'h005, 32'h0);
        loadRequester(3, 1'b0, 9'h009, 32'h0);
        sb.push_back('{idx: 0, rdata: 32'h5, err: 1'b0});
        sb.push_back('{idx: 3, rdata: 32'h9, err: 1'b0});
        runPending(4'b1001);

        repeat (3) @(negedge pclk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
